// File: rtl/deparser_emit_segs_pkg.sv
// Shared definitions for the deparser segment emitter.
// Holds the default bus widths, the FSM state encoding, the captured
// descriptor payload and the segment-count clamping helper.
package deparser_emit_segs_pkg;

    localparam int unsigned C_AXIS_DATA_WIDTH  = 256;
    localparam int unsigned C_AXIS_TUSER_WIDTH = 128;
    localparam int unsigned C_NUM_SEGS         = 4;

    // One header segment is exactly one beat: 32 bytes.
    localparam int unsigned SEG_BYTES  = C_AXIS_DATA_WIDTH / 8;
    localparam int unsigned KEEP_W     = SEG_BYTES;
    localparam int unsigned SEG_CNT_W  = 3;
    localparam int unsigned SEG_IDX_W  = 3;
    localparam int unsigned SEG_SEL_W  = $clog2(C_NUM_SEGS);
    localparam int unsigned PKT_CNT_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_EMIT_SEG  = 2'd1,
        ST_EMIT_BODY = 2'd2
    } state_e;

    // Descriptor as held for the duration of one packet.
    typedef struct packed {
        logic [C_NUM_SEGS-1:0][C_AXIS_DATA_WIDTH-1:0] segs;
        logic [C_AXIS_TUSER_WIDTH-1:0]                tuser;
        logic [SEG_IDX_W-1:0]                         last_idx;
        logic [KEEP_W-1:0]                            last_keep;
        logic                                         more;
    } desc_t;

    // Clamp a requested segment count into 1..C_NUM_SEGS.
    function automatic logic [SEG_CNT_W-1:0] eff_seg_cnt(input logic [SEG_CNT_W-1:0] cnt);
        logic [SEG_CNT_W-1:0] res;
        res = cnt;
        if (cnt == '0) begin
            res = SEG_CNT_W'(1);
        end else if (cnt > SEG_CNT_W'(C_NUM_SEGS)) begin
            res = SEG_CNT_W'(C_NUM_SEGS);
        end
        return res;
    endfunction

endpackage

// File: rtl/deparser_emit_segs.sv
// Deparser segment emitter.
// Accepts a descriptor of up to C_NUM_SEGS header segments, replays them as
// AXI-Stream beats, then optionally forwards the packet body from s_axis.
//
// Ports:
//   axis_clk, aresetn         clock, synchronous active-low reset
//   segs_in / tuser_in / seg_cnt_in / last_keep_in / segs_more_in
//                             descriptor, accepted on segs_valid_in & segs_ready_out
//   s_axis_*                  body stream, passed through after the last segment
//   m_axis_*                  reassembled packet stream
//   pkt_cnt                   emitted-packet count
//
// Build option: define DEPARSER_PKT_CNT_EN to build the packet counter;
// otherwise pkt_cnt is tied to zero.
module deparser_emit_segs
    import deparser_emit_segs_pkg::*;
(
    input  logic                                    axis_clk,
    input  logic                                    aresetn,

    input  logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] segs_in,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]           tuser_in,
    input  logic [SEG_CNT_W-1:0]                    seg_cnt_in,
    input  logic [KEEP_W-1:0]                       last_keep_in,
    input  logic                                    segs_more_in,
    input  logic                                    segs_valid_in,
    output logic                                    segs_ready_out,

    input  logic [C_AXIS_DATA_WIDTH-1:0]            s_axis_tdata,
    input  logic [KEEP_W-1:0]                       s_axis_tkeep,
    input  logic                                    s_axis_tvalid,
    input  logic                                    s_axis_tlast,
    output logic                                    s_axis_tready,

    output logic [C_AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [C_AXIS_TUSER_WIDTH-1:0]           m_axis_tuser,
    output logic [KEEP_W-1:0]                       m_axis_tkeep,
    output logic                                    m_axis_tvalid,
    output logic                                    m_axis_tlast,
    input  logic                                    m_axis_tready,

    output logic [PKT_CNT_W-1:0]                    pkt_cnt
);

    state_e               state_q, state_d;
    logic [SEG_IDX_W-1:0] seg_idx_q, seg_idx_d;
    desc_t                desc_q, desc_d;

    logic [SEG_CNT_W-1:0] cnt_eff;
    logic                 seg_is_last;
    logic                 seg_ends_pkt;
    logic [SEG_SEL_W-1:0] seg_sel;

    // Descriptor normalisation: clamp the count and drop "more" unless every
    // segment slot is used, since the body only ever follows the final slot.
    assign cnt_eff = eff_seg_cnt(seg_cnt_in);

    assign seg_sel      = seg_idx_q[SEG_SEL_W-1:0];
    assign seg_is_last  = (seg_idx_q == desc_q.last_idx);
    assign seg_ends_pkt = seg_is_last && !desc_q.more;

    // State register.
    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            seg_idx_q <= '0;
            desc_q    <= '0;
        end else begin
            state_q   <= state_d;
            seg_idx_q <= seg_idx_d;
            desc_q    <= desc_d;
        end
    end

    // Next-state and stream outputs.
    always_comb begin
        state_d        = state_q;
        seg_idx_d      = seg_idx_q;
        desc_d         = desc_q;
        segs_ready_out = 1'b0;
        s_axis_tready  = 1'b0;
        m_axis_tdata   = '0;
        m_axis_tuser   = '0;
        m_axis_tkeep   = '0;
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                segs_ready_out = 1'b1;
                if (segs_valid_in) begin
                    desc_d.segs      = segs_in;
                    desc_d.tuser     = tuser_in;
                    desc_d.last_idx  = SEG_IDX_W'(cnt_eff - SEG_CNT_W'(1));
                    desc_d.last_keep = last_keep_in;
                    desc_d.more      = segs_more_in && (cnt_eff == SEG_CNT_W'(C_NUM_SEGS));
                    seg_idx_d        = '0;
                    state_d          = ST_EMIT_SEG;
                end
            end

            // Everything shown here comes from registers, so the beat is
            // stable across back-pressure.
            ST_EMIT_SEG: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = desc_q.segs[seg_sel];
                m_axis_tuser  = (seg_idx_q == '0) ? desc_q.tuser : '0;
                m_axis_tkeep  = seg_ends_pkt ? desc_q.last_keep : '1;
                m_axis_tlast  = seg_ends_pkt;
                if (m_axis_tready) begin
                    if (!seg_is_last) begin
                        seg_idx_d = seg_idx_q + SEG_IDX_W'(1);
                    end else if (desc_q.more) begin
                        state_d = ST_EMIT_BODY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_EMIT_BODY: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tkeep  = s_axis_tkeep;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tlast  = s_axis_tlast;
                s_axis_tready = m_axis_tready;
                if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef DEPARSER_PKT_CNT_EN
    logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    // Count completed packets; wraps naturally at 2^32.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`else
    assign pkt_cnt = '0;
`endif

endmodule
